prog_mem_loader: RTL and testbench

PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

---
 rtl/prog_mem_pkg.sv | 19 +
 rtl/sync_ram.sv | 49 ++++
 rtl/prog_mem_loader.sv | 189 ++++++++++++++++++
 tb/tb_prog_mem_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program memory loader.
package prog_mem_pkg;

  // Loader control states: streaming the image, running, or overflowed.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  // Widest word the terminator helper can describe.
  localparam int MAX_WORD_W = 1024;

  // All-ones image terminator for a word of word_w bits (right-aligned).
  function automatic logic [MAX_WORD_W-1:0] terminator(input int word_w);
    return {MAX_WORD_W{1'b1}} >> (MAX_WORD_W - word_w);
  endfunction

endpackage

// File: rtl/sync_ram.sv
// Single-port synchronous RAM, read-first, registered read.
// Out-of-range addresses ignore writes and read back as zero.
module sync_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;
  logic             in_range;

  assign in_range = (32'(addr) < 32'(DEPTH));

  // Read mux: out-of-range reads present zero.
  always_comb begin
    rdata_d = '0;
    if (in_range) begin
      rdata_d = mem[addr];
    end
  end

  // Storage array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[addr] <= wdata;
    end
  end

  // Output register sees the pre-write contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/prog_mem_loader.sv
// Program memory loader: assembles a big-endian byte stream into words,
// writes them to instruction memory until an all-ones terminator, then
// serves instruction fetches. Also hosts a plain data memory port.
// Optional feature: define PROG_MEM_CHECKSUM_EN to add a running checksum
// output summing every word written during the current load.
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int INST_DEPTH = 200,
  parameter int DATA_DEPTH = 10000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [7:0]                      in_byte,
  output logic                            in_ready,
  input  logic                            load_req,
  input  logic [$clog2(INST_DEPTH)-1:0]   if_addr,
  output logic [WORD_W-1:0]               if_data,
  input  logic                            dm_we,
  input  logic [$clog2(DATA_DEPTH)-1:0]   dm_addr,
  input  logic [WORD_W-1:0]               dm_wdata,
  output logic [WORD_W-1:0]               dm_rdata,
  output logic                            boot_done,
  output logic                            load_err,
`ifdef PROG_MEM_CHECKSUM_EN
  output logic [WORD_W-1:0]               checksum,
`endif
  output logic [$clog2(INST_DEPTH+1)-1:0] load_count
);

  localparam int BYTES = WORD_W / 8;
  localparam int BCW   = $clog2(BYTES);
  localparam int IAW   = $clog2(INST_DEPTH);
  localparam int DAW   = $clog2(DATA_DEPTH);
  localparam int LCW   = $clog2(INST_DEPTH + 1);
  localparam logic [WORD_W-1:0] TERM_WORD = WORD_W'(terminator(WORD_W));

  state_e            state_q, state_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              wr_pend_q, wr_pend_d;
  logic [LCW-1:0]    load_count_q, load_count_d;
  logic              boot_done_q, boot_done_d;
  logic              load_err_q, load_err_d;
  logic              if_valid_q, if_valid_d;
`ifdef PROG_MEM_CHECKSUM_EN
  logic [WORD_W-1:0] checksum_q, checksum_d;
`endif

  logic              take;
  logic              word_last;
  logic              imem_we;
  logic [IAW-1:0]    imem_addr;
  logic [WORD_W-1:0] imem_rdata;

  assign in_ready  = (state_q == ST_LOAD);
  // A restart request wins over a byte offered in the same cycle.
  assign take      = in_valid && in_ready && !load_req;
  assign word_last = (byte_cnt_q == BCW'(BYTES - 1));

  // During loading the write pointer owns the instruction RAM port;
  // otherwise the fetch address drives it.
  assign imem_addr = (state_q == ST_LOAD) ? load_count_q[IAW-1:0] : if_addr;

  // Next-state logic: byte assembly, word commit, termination/overflow, restart.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    wr_pend_d    = 1'b0;
    load_count_d = load_count_q;
    boot_done_d  = boot_done_q;
    load_err_d   = load_err_q;
    if_valid_d   = (state_q == ST_RUN);
    imem_we      = 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif

    if (take) begin
      // First byte of a word lands in the most significant lane.
      for (int i = 0; i < BYTES; i++) begin
        if (byte_cnt_q == BCW'(i)) begin
          word_d[WORD_W-1-8*i -: 8] = in_byte;
        end
      end
      byte_cnt_d = word_last ? '0 : byte_cnt_q + BCW'(1);
      wr_pend_d  = word_last;
    end

    // Commit the word completed on the previous cycle.
    if (wr_pend_q && (state_q == ST_LOAD)) begin
      imem_we      = 1'b1;
      load_count_d = load_count_q + LCW'(1);
`ifdef PROG_MEM_CHECKSUM_EN
      checksum_d   = checksum_q + word_q;
`endif
      if (word_q == TERM_WORD) begin
        state_d     = ST_RUN;
        boot_done_d = 1'b1;
      end else if (load_count_q == LCW'(INST_DEPTH - 1)) begin
        state_d    = ST_ERR;
        load_err_d = 1'b1;
      end
    end

    // Restart discards any partial or pending word.
    if (load_req) begin
      state_d      = ST_LOAD;
      byte_cnt_d   = '0;
      wr_pend_d    = 1'b0;
      load_count_d = '0;
      boot_done_d  = 1'b0;
      load_err_d   = 1'b0;
      if_valid_d   = 1'b0;
      imem_we      = 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
      checksum_d   = '0;
`endif
    end
  end

  // Control and assembly registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      wr_pend_q    <= 1'b0;
      load_count_q <= '0;
      boot_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      if_valid_q   <= 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      wr_pend_q    <= wr_pend_d;
      load_count_q <= load_count_d;
      boot_done_q  <= boot_done_d;
      load_err_q   <= load_err_d;
      if_valid_q   <= if_valid_d;
`ifdef PROG_MEM_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  sync_ram #(
    .WIDTH (WORD_W),
    .DEPTH (INST_DEPTH),
    .AW    (IAW)
  ) u_imem (
    .clk   (clk),
    .rst   (rst),
    .we    (imem_we),
    .addr  (imem_addr),
    .wdata (word_q),
    .rdata (imem_rdata)
  );

  sync_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DATA_DEPTH),
    .AW    (DAW)
  ) u_dmem (
    .clk   (clk),
    .rst   (rst),
    .we    (dm_we),
    .addr  (dm_addr),
    .wdata (dm_wdata),
    .rdata (dm_rdata)
  );

  // Fetch data only leaves the block for reads issued while running.
  assign if_data    = if_valid_q ? imem_rdata : '0;
  assign boot_done  = boot_done_q;
  assign load_err   = load_err_q;
  assign load_count = load_count_q;
`ifdef PROG_MEM_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: a default-size instance and a
// 4-word instruction memory instance for the overflow path.
module tb_prog_mem_loader;

  localparam int K_IF = 0, K_DM = 1, K_LC = 2, K_BOOT = 3, K_ERR = 4, K_RDY = 5, K_CSUM = 6;
  localparam int K_S_LC = 7, K_S_ERR = 8, K_S_RDY = 9, K_S_BOOT = 10, K_S_IF = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // default-size instance
  logic        in_valid, load_req, dm_we;
  logic [7:0]  in_byte, if_addr;
  logic [13:0] dm_addr;
  logic [31:0] dm_wdata;
  wire         in_ready, boot_done, load_err;
  wire  [31:0] if_data, dm_rdata;
  wire  [7:0]  load_count;
  // small instance
  logic        s_in_valid, s_load_req, s_dm_we;
  logic [7:0]  s_in_byte;
  logic [1:0]  s_if_addr;
  logic [3:0]  s_dm_addr;
  logic [31:0] s_dm_wdata;
  wire         s_in_ready, s_boot_done, s_load_err;
  wire  [31:0] s_if_data, s_dm_rdata;
  wire  [2:0]  s_load_count;
`ifdef PROG_MEM_CHECKSUM_EN
  wire  [31:0] checksum, s_checksum;
`endif

  prog_mem_loader #(.WORD_W(32), .INST_DEPTH(200), .DATA_DEPTH(10000)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .load_req(load_req), .if_addr(if_addr), .if_data(if_data), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .boot_done(boot_done),
    .load_err(load_err),
`ifdef PROG_MEM_CHECKSUM_EN
    .checksum(checksum),
`endif
    .load_count(load_count)
  );

  prog_mem_loader #(.WORD_W(32), .INST_DEPTH(4), .DATA_DEPTH(16)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_byte(s_in_byte), .in_ready(s_in_ready),
    .load_req(s_load_req), .if_addr(s_if_addr), .if_data(s_if_data), .dm_we(s_dm_we),
    .dm_addr(s_dm_addr), .dm_wdata(s_dm_wdata), .dm_rdata(s_dm_rdata), .boot_done(s_boot_done),
    .load_err(s_load_err),
`ifdef PROG_MEM_CHECKSUM_EN
    .checksum(s_checksum),
`endif
    .load_count(s_load_count)
  );

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_IF:     return if_data;
      K_DM:     return dm_rdata;
      K_LC:     return 32'(load_count);
      K_BOOT:   return 32'(boot_done);
      K_ERR:    return 32'(load_err);
      K_RDY:    return 32'(in_ready);
`ifdef PROG_MEM_CHECKSUM_EN
      K_CSUM:   return checksum;
`endif
      K_S_LC:   return 32'(s_load_count);
      K_S_ERR:  return 32'(s_load_err);
      K_S_RDY:  return 32'(s_in_ready);
      K_S_BOOT: return 32'(s_boot_done);
      K_S_IF:   return s_if_data;
      default:  return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Queue an expectation to be checked lat cycles from now.
  task automatic expect_at(input int kind, input logic [31:0] exp, input int lat, input string name);
    exp_t e;
    e.due  = cyc + lat;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: retire every expectation that falls due this cycle.
  always @(negedge clk) begin : mon
    int          i;
    logic [31:0] act;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].due <= cyc) begin
        total++;
        act = observe(exp_q[i].kind);
        if (exp_q[i].due < cyc) begin
          bad++;
          $display("FAIL %s: check overdue at cycle %0d (due %0d)", exp_q[i].name, cyc, exp_q[i].due);
        end else if (act !== exp_q[i].exp) begin
          bad++;
          $display("FAIL %s: got %h want %h (cycle %0d)", exp_q[i].name, act, exp_q[i].exp, cyc);
        end else begin
          $display("ok   %s: %h (cycle %0d)", exp_q[i].name, act, cyc);
        end
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until the loader accepts it (bounded).
  task automatic send_byte(input bit sm, input logic [7:0] b);
    bit rdy;
    bit done;
    done = 1'b0;
    if (sm) begin s_in_valid = 1'b1; s_in_byte = b; end
    else    begin in_valid   = 1'b1; in_byte   = b; end
    for (int n = 0; n < 50 && !done; n++) begin
      rdy = sm ? s_in_ready : in_ready;
      step();
      done = rdy;
    end
    s_in_valid = 1'b0;
    in_valid   = 1'b0;
    if (!done) expect_at(sm ? K_S_RDY : K_RDY, 32'd1, 0, "handshake_timeout");
  endtask

  task automatic send_word(input bit sm, input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps) repeat ($urandom_range(2, 0)) step();
      send_byte(sm, w[31-8*i -: 8]);
    end
  endtask

  logic [31:0] img [44];
  logic [31:0] sum;

  initial begin
    rst = 1'b1;
    in_valid = 0; in_byte = 0; load_req = 0; if_addr = 0;
    dm_we = 0; dm_addr = 0; dm_wdata = 0;
    s_in_valid = 0; s_in_byte = 0; s_load_req = 0; s_if_addr = 0;
    s_dm_we = 0; s_dm_addr = 0; s_dm_wdata = 0;
    repeat (3) step();
    rst = 1'b0;

    // reset state
    expect_at(K_RDY,   32'd1, 0, "rst_in_ready");
    expect_at(K_LC,    32'd0, 0, "rst_load_count");
    expect_at(K_BOOT,  32'd0, 0, "rst_boot_done");
    expect_at(K_ERR,   32'd0, 0, "rst_load_err");
    expect_at(K_IF,    32'd0, 0, "rst_if_data");
    expect_at(K_DM,    32'd0, 0, "rst_dm_rdata");
    expect_at(K_S_RDY, 32'd1, 0, "rst_small_in_ready");
`ifdef PROG_MEM_CHECKSUM_EN
    expect_at(K_CSUM,  32'd0, 0, "rst_checksum");
`endif
    // fetch while loading returns zero
    if_addr = 8'd0;
    expect_at(K_IF, 32'd0, 1, "load_fetch_zero");
    step();

    // partial word then restart: the two bytes must be discarded
    send_byte(1'b0, 8'hAA);
    send_byte(1'b0, 8'hBB);
    load_req = 1'b1; in_valid = 1'b1; in_byte = 8'h55;
    step();
    load_req = 1'b0; in_valid = 1'b0;
    expect_at(K_LC,  32'd0, 0, "restart_load_count");
    expect_at(K_RDY, 32'd1, 0, "restart_in_ready");

    // 20 01 00 03 FF FF FF FF
    send_word(1'b0, 32'h2001_0003, 1'b0);
    expect_at(K_LC, 32'd0, 0, "word0_before_write");
    step();
    expect_at(K_LC, 32'd1, 0, "word0_written");
    send_word(1'b0, 32'hFFFF_FFFF, 1'b0);
    expect_at(K_BOOT, 32'd0, 0, "term_before_write");
    step();
    expect_at(K_BOOT, 32'd1, 0, "boot_done_set");
    expect_at(K_LC,   32'd2, 0, "boot_load_count");
    expect_at(K_RDY,  32'd0, 0, "run_in_ready");
    expect_at(K_ERR,  32'd0, 0, "run_load_err");
`ifdef PROG_MEM_CHECKSUM_EN
    expect_at(K_CSUM, 32'h2001_0002, 0, "boot_checksum");
`endif

    // fetches in RUN
    if_addr = 8'd0;   expect_at(K_IF, 32'h2001_0003, 1, "fetch_0"); step();
    if_addr = 8'd1;   expect_at(K_IF, 32'hFFFF_FFFF, 1, "fetch_1"); step();
    if_addr = 8'd250; expect_at(K_IF, 32'd0,         1, "fetch_oob"); step();

    // data memory
    dm_we = 1; dm_addr = 14'd5; dm_wdata = 32'hDEAD_BEEF; step();
    dm_we = 0; expect_at(K_DM, 32'hDEAD_BEEF, 1, "dm_read_5"); step();
    dm_we = 1; dm_wdata = 32'h1; expect_at(K_DM, 32'hDEAD_BEEF, 1, "dm_read_first"); step();
    dm_we = 0; expect_at(K_DM, 32'h1, 1, "dm_read_new"); step();
    dm_we = 1; dm_addr = 14'd10000; dm_wdata = 32'h1234_5678; expect_at(K_DM, 32'd0, 1, "dm_oob_wr_cycle"); step();
    dm_we = 0; expect_at(K_DM, 32'd0, 1, "dm_oob_read"); step();
    dm_we = 1; dm_addr = 14'd9999; dm_wdata = 32'hCAFE_F00D; step();
    dm_we = 0; expect_at(K_DM, 32'hCAFE_F00D, 1, "dm_last_addr"); step();

    // 44-word load with random gaps
    load_req = 1'b1; step(); load_req = 1'b0;
    expect_at(K_BOOT, 32'd0, 0, "reload_boot_clear");
    expect_at(K_LC,   32'd0, 0, "reload_count_clear");
`ifdef PROG_MEM_CHECKSUM_EN
    expect_at(K_CSUM, 32'd0, 0, "reload_checksum_clear");
`endif
    sum = 32'd0;
    for (int i = 0; i < 44; i++) begin
      img[i] = (i == 43) ? 32'hFFFF_FFFF : 32'h1000_0000 + 32'(i) * 32'h0102_0304;
      sum = sum + img[i];
    end
    for (int i = 0; i < 43; i++) send_word(1'b0, img[i], 1'b1);
    step(); step();
    expect_at(K_BOOT, 32'd0,  0, "long_no_boot_early");
    expect_at(K_LC,   32'd43, 0, "long_count_43");
    send_word(1'b0, img[43], 1'b1);
    step();
    expect_at(K_BOOT, 32'd1,  0, "long_boot_done");
    expect_at(K_LC,   32'd44, 0, "long_count_44");
`ifdef PROG_MEM_CHECKSUM_EN
    expect_at(K_CSUM, sum, 0, "long_checksum");
`endif
    for (int i = 0; i < 44; i++) begin
      if_addr = 8'(i);
      expect_at(K_IF, img[i], 1, $sformatf("long_fetch_%0d", i));
      step();
    end

    // small instance: overflow into ERR, then restart and a clean load
    for (int i = 0; i < 3; i++) send_word(1'b1, 32'h1111_1111 * 32'(i + 1), 1'b0);
    step();
    expect_at(K_S_LC,  32'd3, 0, "small_count_3");
    expect_at(K_S_ERR, 32'd0, 0, "small_no_err_yet");
    send_word(1'b1, 32'h4444_4444, 1'b0);
    step();
    expect_at(K_S_ERR, 32'd1, 0, "small_load_err");
    expect_at(K_S_RDY, 32'd0, 0, "small_err_in_ready");
    expect_at(K_S_LC,  32'd4, 0, "small_err_count");
    s_load_req = 1'b1; step(); s_load_req = 1'b0;
    expect_at(K_S_ERR, 32'd0, 0, "small_err_cleared");
    expect_at(K_S_LC,  32'd0, 0, "small_count_cleared");
    expect_at(K_S_RDY, 32'd1, 0, "small_ready_again");
    for (int i = 0; i < 3; i++) send_word(1'b1, 32'hA0A0_0000 + 32'(i), 1'b0);
    send_word(1'b1, 32'hFFFF_FFFF, 1'b0);
    step();
    expect_at(K_S_BOOT, 32'd1, 0, "small_term_at_last");
    expect_at(K_S_ERR,  32'd0, 0, "small_term_no_err");
    expect_at(K_S_LC,   32'd4, 0, "small_term_count");
    s_if_addr = 2'd3; expect_at(K_S_IF, 32'hFFFF_FFFF, 1, "small_fetch_3"); step();
    s_if_addr = 2'd0; expect_at(K_S_IF, 32'hA0A0_0000, 1, "small_fetch_0"); step();

    repeat (3) step();
    if (exp_q.size() != 0) begin
      repeat (2) step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
